uart_frac_baud_gen: RTL and testbench

//   Parametrised fractional baud-rate generator for the UART core.
//   It replaces the fixed 16-bit DL counter in the register block with a

---
 rtl/uart_frac_baud_gen.sv | 98 +++++++++
 tb/tb_uart_frac_baud_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frac_baud_gen.sv
// uart_frac_baud_gen
//   Fractional baud-rate generator for the UART core. The divisor is
//   D + F/2^FRAC_W. Each enable period is D or D+1 clocks. A phase
//   accumulator picks the longer period whenever its sum carries. Every OVS
//   enables make one bit period. sync_i realigns the bit phase to a receiver
//   start-bit edge.
// Ports
//   clk         system clock
//   wb_rst_i    asynchronous reset, active high
//   dl_i        new integer divisor D
//   dlf_i       new fractional divisor F
//   load_i      strobe: latch dl_i/dlf_i and restart the phase
//   sync_i      strobe: restart the current divisor's phase (acc kept)
//   enable_o    registered 1-cycle oversample tick
//   bit_tick_o  registered tick on the last enable of each bit period
//   mid_tick_o  registered tick on the enable at bit centre
//   active_o    high while the active divisor is non-zero
module uart_frac_baud_gen #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int OVS_W    = 4,
  parameter int RESET_DL = 0
) (
  input  logic              clk,
  input  logic              wb_rst_i,
  input  logic [DIV_W-1:0]  dl_i,
  input  logic [FRAC_W-1:0] dlf_i,
  input  logic              load_i,
  input  logic              sync_i,
  output logic              enable_o,
  output logic              bit_tick_o,
  output logic              mid_tick_o,
  output logic              active_o
);

  localparam logic [DIV_W-1:0] RST_DL   = DIV_W'(RESET_DL);
  localparam logic [DIV_W-1:0] RST_DLC  = (RESET_DL == 0) ? '0 : DIV_W'(RESET_DL - 1);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

  logic [DIV_W-1:0]  dl_r, dlc, dl_m1;
  logic [FRAC_W-1:0] dlf_r, acc, acc_nxt;
  logic [OVS_W-1:0]  ovs_cnt;
  logic              armed;   // low only until the first edge after reset
  logic              run, carry, expire;

  always_comb begin
    run              = (dl_r != '0);
    dl_m1            = dl_r - DIV_W'(1);
    {carry, acc_nxt} = {1'b0, acc} + {1'b0, dlf_r};
    // load and sync both pre-empt an expiring count
    expire           = run && armed && (dlc == '0) && !load_i && !sync_i;
  end

  assign active_o = run;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      dl_r       <= RST_DL;
      dlf_r      <= '0;
      dlc        <= RST_DLC;
      acc        <= '0;
      ovs_cnt    <= '0;
      armed      <= 1'b0;
      enable_o   <= 1'b0;
      bit_tick_o <= 1'b0;
      mid_tick_o <= 1'b0;
    end else begin
      armed      <= 1'b1;
      enable_o   <= expire;
      bit_tick_o <= expire && (ovs_cnt == OVS_LAST);
      mid_tick_o <= expire && (ovs_cnt == OVS_MID);
      if (load_i) begin
        dl_r    <= dl_i;
        dlf_r   <= dlf_i;
        dlc     <= (dl_i == '0) ? '0 : dl_i - DIV_W'(1);
        acc     <= '0;
        ovs_cnt <= '0;
      end else if (!run) begin
        dlc     <= '0;
        acc     <= '0;
        ovs_cnt <= '0;
      end else if (sync_i) begin
        dlc     <= dl_m1;
        ovs_cnt <= '0;
      end else if (dlc != '0) begin
        dlc <= dlc - DIV_W'(1);
      end else if (expire) begin
        // A carry out of the accumulator stretches the next period by one clock
        acc     <= acc_nxt;
        dlc     <= carry ? dl_r : dl_m1;
        ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
module tb_uart_frac_baud_gen;
  localparam int OVS  = 16;
  localparam int FMOD = 16;   // 2^FRAC_W

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [15:0] dl_i = '0;
  logic [3:0]  dlf_i = '0;
  logic        load_i = 1'b0, sync_i = 1'b0;
  logic        enable_o, bit_tick_o, mid_tick_o, active_o;

  uart_frac_baud_gen #(.DIV_W(16), .FRAC_W(4), .OVS(16), .OVS_W(4), .RESET_DL(0)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .dl_i(dl_i), .dlf_i(dlf_i),
    .load_i(load_i), .sync_i(sync_i), .enable_o(enable_o),
    .bit_tick_o(bit_tick_o), .mid_tick_o(mid_tick_o), .active_o(active_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int en_q[$], bit_q[$], mid_q[$];

  // Event-time model: each enable is scheduled at an absolute edge number.
  // The fractional phase accumulates F and lengthens the next period when it wraps.
  int m_dl = 0, m_f = 0, m_acc = 0, m_n = 0, m_next = 0;
  bit exp_en = 0, exp_bit = 0, exp_mid = 0, exp_act = 0;

  task automatic chk(input string nm, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got %0d want %0d (edge %0d)", nm, got, want, cyc);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_reset();
    m_dl = 0; m_f = 0; m_acc = 0; m_n = 0;
    exp_en = 0; exp_bit = 0; exp_mid = 0; exp_act = 0;
  endtask

  task automatic model_edge();
    cyc++;
    exp_en = 0; exp_bit = 0; exp_mid = 0;
    if (wb_rst_i) begin
      model_reset();
    end else if (load_i) begin
      m_dl = int'(dl_i); m_f = int'(dlf_i); m_acc = 0; m_n = 0;
      m_next = cyc + m_dl;
    end else if (m_dl != 0 && sync_i) begin
      m_next = cyc + m_dl; m_n = 0;
    end else if (m_dl != 0 && cyc == m_next) begin
      exp_en  = 1;
      exp_bit = (m_n % OVS) == OVS - 1;
      exp_mid = (m_n % OVS) == OVS / 2 - 1;
      m_n++;
      m_acc += m_f;
      if (m_acc >= FMOD) begin
        m_acc -= FMOD;
        m_next = cyc + m_dl + 1;
      end else begin
        m_next = cyc + m_dl;
      end
    end
    exp_act = (m_dl != 0);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("enable_o",   int'(enable_o),   int'(exp_en));
      chk("bit_tick_o", int'(bit_tick_o), int'(exp_bit));
      chk("mid_tick_o", int'(mid_tick_o), int'(exp_mid));
      chk("active_o",   int'(active_o),   int'(exp_act));
    end
    if (enable_o)   en_q.push_back(cyc);
    if (bit_tick_o) bit_q.push_back(cyc);
    if (mid_tick_o) mid_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clrq();
    en_q.delete(); bit_q.delete(); mid_q.delete();
  endtask

  task automatic load(input int d, input int f, input bit s, output int t);
    dl_i = 16'(d); dlf_i = 4'(f); load_i = 1'b1; sync_i = s;
    tick();
    load_i = 1'b0; sync_i = 1'b0;
    t = cyc;
  endtask

  initial begin
    int t, s;
    // reset state
    run(3);
    chk("rst enable_o", int'(enable_o), 0);
    chk("rst bit_tick_o", int'(bit_tick_o), 0);
    chk("rst mid_tick_o", int'(mid_tick_o), 0);
    chk("rst active_o", int'(active_o), 0);
    chk_on = 1'b1;
    wb_rst_i = 1'b0;
    clrq();
    run(4);
    chk("idle no enables", en_q.size(), 0);

    // D=4 F=0: enable every 4 edges, mid on 8th, bit on 16th
    clrq(); load(4, 0, 0, t); run(70);
    chk("d4 en0", qat(en_q, 0), t + 4);
    chk("d4 en1", qat(en_q, 1), t + 8);
    chk("d4 en2", qat(en_q, 2), t + 12);
    chk("d4 count", en_q.size(), 17);
    chk("d4 mid", qat(mid_q, 0), t + 32);
    chk("d4 bit", qat(bit_q, 0), t + 64);

    // D=4 F=8: acc 8,0,8,0... -> intervals 4,4,5,4,5,4
    clrq(); load(4, 8, 0, t); run(40);
    chk("frac int0", qat(en_q, 0) - t, 4);
    chk("frac int1", qat(en_q, 1) - qat(en_q, 0), 4);
    chk("frac int2", qat(en_q, 2) - qat(en_q, 1), 5);
    chk("frac int3", qat(en_q, 3) - qat(en_q, 2), 4);
    chk("frac int4", qat(en_q, 4) - qat(en_q, 3), 5);
    chk("frac int5", qat(en_q, 5) - qat(en_q, 4), 4);

    // D=1 F=0: enable every cycle; then D=0 stops everything
    clrq(); load(1, 0, 0, t); run(40);
    chk("d1 count", en_q.size(), 40);
    chk("d1 mid", qat(mid_q, 0), t + 8);
    chk("d1 bit0", qat(bit_q, 0), t + 16);
    chk("d1 bit1", qat(bit_q, 1), t + 32);
    load(0, 0, 0, t); clrq(); run(10);
    chk("d0 no enables", en_q.size(), 0);
    chk("d0 no bit ticks", bit_q.size(), 0);
    chk("d0 active_o", int'(active_o), 0);

    // D=10: sync at the edge where ovs_cnt=5 and dlc=3
    clrq(); load(10, 0, 0, t); run(56);
    chk("sync pre enables", en_q.size(), 5);
    clrq();
    sync_i = 1'b1; tick(); sync_i = 1'b0; s = cyc;
    run(170);
    chk("sync first en", qat(en_q, 0), s + 10);
    chk("sync mid", qat(mid_q, 0), s + 80);
    chk("sync bit", qat(bit_q, 0), s + 160);

    // load beats sync; acc cleared (a stale acc=8 would give 3,4 not 3,3)
    load(6, 8, 0, t); run(8);
    clrq(); load(3, 8, 1, t); run(12);
    chk("ldsync en0", qat(en_q, 0), t + 3);
    chk("ldsync en1", qat(en_q, 1), t + 6);
    chk("ldsync en2", qat(en_q, 2), t + 10);

    // async reset right after an enable with D=8
    load(8, 0, 0, t); run(16);
    chk("pre-rst enable_o", int'(enable_o), 1);
    wb_rst_i = 1'b1; model_reset();
    #1;
    chk("async rst enable_o", int'(enable_o), 0);
    chk("async rst active_o", int'(active_o), 0);
    chk("async rst bit_tick_o", int'(bit_tick_o), 0);
    chk("async rst mid_tick_o", int'(mid_tick_o), 0);
    run(3);
    wb_rst_i = 1'b0;
    clrq(); run(20);
    chk("post-rst no enables", en_q.size(), 0);
    chk("post-rst active_o", int'(active_o), 0);
    load(2, 0, 0, t); run(6);
    chk("post-rst reload en0", qat(en_q, 0), t + 2);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
